// File: rtl/mem_port_arbiter.sv
// Shares one SRAM port between instruction fetch and the MEM stage.
// Each grant runs a fixed-length access and then pulses ready to its owner.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                own_mem_q, own_mem_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

  // Byte-offset and high address bits never reach the word-addressed SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      own_mem_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_mem_q   <= own_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_mem_d   = own_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        // MEM wins over fetch; a simultaneous rd+wr is a store.
        if (mem_rd || mem_wr) begin
          state_d   = S_ACCESS;
          cnt_d     = CNT_W'(WAIT_CYCLES - 1);
          own_mem_d = 1'b1;
          we_d      = mem_wr;
          addr_d    = mem_addr[ADDR_W+1:2];
          wdata_d   = mem_wdata;
        end else if (if_req) begin
          state_d   = S_ACCESS;
          cnt_d     = CNT_W'(WAIT_CYCLES - 1);
          own_mem_d = 1'b0;
          we_d      = 1'b0;
          addr_d    = if_addr[ADDR_W+1:2];
          wdata_d   = mem_wdata;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (own_mem_q) mem_rdata_d = sram_rdata;
            else           if_rdata_d  = sram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sram_en    = (state_q == S_ACCESS);
    sram_we    = (state_q == S_ACCESS) && we_q;
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
    if_ready   = (state_q == S_DONE) && !own_mem_q;
    mem_ready  = (state_q == S_DONE) && own_mem_q;
    if_rdata   = if_rdata_q;
    mem_rdata  = mem_rdata_q;
  end

endmodule
